// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_mem_pkg;

  // Fetch FSM states: idle, counting down the latency, presenting the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } instr_mem_state_e;

  // Instruction driven when no fetched word is valid (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Latency counter width; covers LATENCY values 1..15.
  localparam int LAT_CNT_W = 4;

  // True when a byte address is not aligned to a 32-bit word.
  function automatic logic addr_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch-port and backdoor-load signal bundle for the instruction responder.
// Latency: n/a (wiring only).
// Backpressure: none; requests are sampled only when the responder can accept.
interface instr_mem_responder_if #(
  parameter int unsigned DEPTH = 4096
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic             instr_mem_en;
  logic [31:0]      instr_mem_address;
  logic             instr_mem_flush;
  logic [31:0]      instr_mem_read;
  logic             instr_ready;
  logic             busy;
  logic             misalign;
  logic             load_we;
  logic [IDX_W-1:0] load_addr;
  logic [31:0]      load_data;

  // Responder side.
  modport slave (
    input  instr_mem_en, instr_mem_address, instr_mem_flush,
    input  load_we, load_addr, load_data,
    output instr_mem_read, instr_ready, busy, misalign
  );

  // Fetch-unit / bench driver side.
  modport master (
    output instr_mem_en, instr_mem_address, instr_mem_flush,
    output load_we, load_addr, load_data,
    input  instr_mem_read, instr_ready, busy, misalign
  );

endinterface

// File: rtl/instr_mem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one synchronous read port.
// Latency: read data appears one edge after i_re; writes land at the edge.
// Backpressure: none; a same-edge read and write to one word returns the old word.
module instr_mem_array #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Backdoor write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; nonblocking update gives read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: answers each fetch with a memory word after LATENCY cycles.
// Latency: accept at edge N -> one-cycle instr_ready in cycle N+LATENCY; no bubble on back-to-back.
// Backpressure: one fetch in flight; requests ignored in WAIT; flush cancels.
// Optional: INSTR_MEM_MISALIGN_CHECK_EN flags non-word-aligned fetches and returns NOP_INSTR.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  instr_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(LATENCY - 1);
  localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);
  localparam logic                 LAT_ONE  = (LATENCY == 1);

  instr_mem_state_e     r_state;
  instr_mem_state_e     w_next_state;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic [LAT_CNT_W-1:0] w_cnt_next;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_req_idx;
  logic [IDX_W-1:0]     w_rd_addr;
  logic                 r_mis;
  logic                 r_use_nop;
  logic                 w_req_mis;
  logic                 w_load_mis;
  logic                 w_can_accept;
  logic                 w_accept;
  logic                 w_wait_done;
  logic                 w_load;
  logic [31:0]          w_rd_data;
  logic                 w_unused_addr_hi;

  // Word index of the incoming request; upper bits dropped so addresses wrap.
  assign w_req_idx        = bus.instr_mem_address[IDX_W+1:2];
  assign w_unused_addr_hi = ^bus.instr_mem_address[31:IDX_W+2];

`ifdef INSTR_MEM_MISALIGN_CHECK_EN
  assign w_req_mis    = addr_misaligned(bus.instr_mem_address[1:0]);
  assign bus.misalign = (r_state == RESP) && r_mis;
`else
  logic w_unused_addr_lo;
  assign w_unused_addr_lo = ^bus.instr_mem_address[1:0];
  assign w_req_mis        = 1'b0;
  assign bus.misalign     = 1'b0;
`endif

  // A request is taken in IDLE or RESP unless flush is asserted alongside it.
  assign w_can_accept = (r_state == IDLE) || (r_state == RESP);
  assign w_accept     = w_can_accept && bus.instr_mem_en && !bus.instr_mem_flush;

  // Last WAIT cycle: the counter steps to zero on this edge.
  assign w_wait_done  = (r_state == WAIT) && (r_cnt <= CNT_ONE) && !bus.instr_mem_flush;

  // Data is fetched on the edge that enters RESP; with LATENCY 1 that is the accept edge.
  assign w_load     = w_wait_done || (LAT_ONE && w_accept);
  assign w_rd_addr  = (r_state == WAIT) ? r_idx : w_req_idx;
  assign w_load_mis = (r_state == WAIT) ? r_mis : w_req_mis;

  // Next-state and counter: flush overrides everything, WAIT counts down to RESP.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    if (bus.instr_mem_flush) begin
      w_next_state = IDLE;
      w_cnt_next   = '0;
    end else begin
      unique case (r_state)
        IDLE, RESP: begin
          if (bus.instr_mem_en) begin
            w_next_state = LAT_ONE ? RESP : WAIT;
            w_cnt_next   = CNT_LOAD;
          end else begin
            w_next_state = IDLE;
          end
        end
        WAIT: begin
          w_cnt_next = r_cnt - CNT_ONE;
          if (r_cnt <= CNT_ONE) begin
            w_next_state = RESP;
          end
        end
        default: begin
          w_next_state = IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // State, counter, captured request and output-select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_mis     <= 1'b0;
      r_use_nop <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_idx <= w_req_idx;
        r_mis <= w_req_mis;
      end
      // NOP after flush; a misaligned response also reads back as NOP.
      if (bus.instr_mem_flush) begin
        r_use_nop <= 1'b1;
      end else if (w_load) begin
        r_use_nop <= w_load_mis;
      end
    end
  end

  instr_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (bus.load_we),
    .i_waddr (bus.load_addr),
    .i_wdata (bus.load_data),
    .i_re    (w_load && !rst),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // All outputs come from registers or state only.
  assign bus.instr_mem_read = r_use_nop ? NOP_INSTR : w_rd_data;
  assign bus.instr_ready    = (r_state == RESP);
  assign bus.busy           = (r_state == WAIT);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder (DEPTH 16, LATENCY 2).
// Latency: responses expected LATENCY cycles after each accepted request.
// Backpressure: bench presents requests only in IDLE/RESP unless testing rejection.
module tb_instr_mem_responder;
  import instr_mem_pkg::*;

  localparam int          DEPTH = 16;
  localparam int          IDX_W = $clog2(DEPTH);
  localparam int          LAT   = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_responder_if #(.DEPTH(DEPTH)) bus();

  instr_mem_responder #(
    .DEPTH     (DEPTH),
    .LATENCY   (LAT),
    .NOP_INSTR (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        mis;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;
  int   pushed   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic m);
    sb_q.push_back('{d, m});
    pushed++;
  endtask

  // Scoreboard: every instr_ready pulse pops and compares one expected response.
  always @(negedge clk) begin
    if (bus.instr_ready === 1'b1) begin
      pulses++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got instr_ready=1 at %0t expected no response", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_data", bus.instr_mem_read, mon_e.data);
        check("resp_misalign", 32'(bus.misalign), 32'(mon_e.mis));
      end
    end
  end

  // Present one request from IDLE and check the accept-to-ready latency.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] d, input logic m, input string name);
    int  lat;
    logic got;
    push(d, m);
    bus.instr_mem_en      = 1'b1;
    bus.instr_mem_address = addr;
    step();
    bus.instr_mem_en = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.instr_ready === 1'b1) got = 1'b1;
    end
    check({name, "_latency"}, 32'(lat), 32'(LAT));
    step();
  endtask

  // Count instr_ready pulses over n cycles; a cancelled fetch must produce none.
  task automatic quiet(input int n, input string name);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.instr_ready === 1'b1) cnt++;
    end
    check(name, 32'(cnt), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rv;
    rst                   = 1'b1;
    bus.instr_mem_en      = 1'b0;
    bus.instr_mem_address = '0;
    bus.instr_mem_flush   = 1'b0;
    bus.load_we           = 1'b0;
    bus.load_addr         = '0;
    bus.load_data         = '0;

    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'hA000_0000, 1'b0};
    vecs[2] = '{32'h0000_003C, 32'hA000_000F, 1'b0};
    vecs[3] = '{32'h0000_0040, 32'hA000_0000, 1'b0};
    vecs[4] = '{32'h0000_0044, 32'hA000_0001, 1'b0};
    vecs[5] = '{32'hFFFF_FFF8, 32'hA000_000E, 1'b0};
`ifdef INSTR_MEM_MISALIGN_CHECK_EN
    vecs[6] = '{32'h0000_0012, 32'h0000_0013, 1'b1};
    vecs[7] = '{32'h0000_002B, 32'h0000_0013, 1'b1};
`else
    vecs[6] = '{32'h0000_0012, 32'hDEAD_BEEF, 1'b0};
    vecs[7] = '{32'h0000_002B, 32'hA000_000A, 1'b0};
`endif

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_read", bus.instr_mem_read, NOP);
    check("rst_ready", 32'(bus.instr_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_misalign", 32'(bus.misalign), 32'd0);
    step();

    // Backdoor preload.
    for (int i = 0; i < DEPTH; i++) begin
      bus.load_we   = 1'b1;
      bus.load_addr = IDX_W'(i);
      bus.load_data = (i == 4) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(i));
      step();
    end
    bus.load_we = 1'b0;

    // Table-driven single fetches.
    for (int i = 0; i < 8; i++) begin
      fetch(vecs[i].addr, vecs[i].data, vecs[i].mis, $sformatf("vec%0d", i));
    end

    // Basic read: busy in cycle 1, ready only in cycle 2.
    push(32'hDEAD_BEEF, 1'b0);
    bus.instr_mem_en      = 1'b1;
    bus.instr_mem_address = 32'h10;
    @(negedge clk);
    check("basic_c0_busy", 32'(bus.busy), 32'd0);
    step();
    bus.instr_mem_en = 1'b0;
    @(negedge clk);
    check("basic_c1_busy", 32'(bus.busy), 32'd1);
    check("basic_c1_ready", 32'(bus.instr_ready), 32'd0);
    step();
    @(negedge clk);
    check("basic_c2_ready", 32'(bus.instr_ready), 32'd1);
    check("basic_c2_busy", 32'(bus.busy), 32'd0);
    step();
    @(negedge clk);
    check("basic_c3_ready", 32'(bus.instr_ready), 32'd0);
    step();

    // Back-to-back: en held, real addresses only in acceptance cycles.
    push(32'hA000_0000, 1'b0);
    push(32'hA000_0001, 1'b0);
    push(32'hA000_0002, 1'b0);
    rv = '0;
    for (int c = 0; c < 8; c++) begin
      bus.instr_mem_en = (c < 5);
      case (c)
        0:       bus.instr_mem_address = 32'h0;
        2:       bus.instr_mem_address = 32'h4;
        4:       bus.instr_mem_address = 32'h8;
        default: bus.instr_mem_address = 32'h3C;
      endcase
      @(negedge clk);
      rv[c] = bus.instr_ready;
      step();
    end
    check("b2b_ready_cycles", 32'(rv), 32'h54);

    // Flush mid-fetch, with a request presented alongside the flush.
    bus.instr_mem_en      = 1'b1;
    bus.instr_mem_address = 32'h10;
    step();
    bus.instr_mem_address = 32'h0;
    bus.instr_mem_flush   = 1'b1;
    step();
    bus.instr_mem_en    = 1'b0;
    bus.instr_mem_flush = 1'b0;
    @(negedge clk);
    check("flush_read", bus.instr_mem_read, NOP);
    check("flush_busy", 32'(bus.busy), 32'd0);
    quiet(6, "flush_no_resp");

    // Flush in the RESP cycle: that pulse stands, the new request is dropped.
    push(32'hA000_0000, 1'b0);
    bus.instr_mem_en      = 1'b1;
    bus.instr_mem_address = 32'h0;
    step();
    bus.instr_mem_en = 1'b0;
    step();
    bus.instr_mem_en      = 1'b1;
    bus.instr_mem_address = 32'h4;
    bus.instr_mem_flush   = 1'b1;
    @(negedge clk);
    check("flush_resp_ready", 32'(bus.instr_ready), 32'd1);
    step();
    bus.instr_mem_en    = 1'b0;
    bus.instr_mem_flush = 1'b0;
    @(negedge clk);
    check("flush_resp_read", bus.instr_mem_read, NOP);
    check("flush_resp_busy", 32'(bus.busy), 32'd0);
    quiet(6, "flush_resp_no_resp");

    // Wrap plus write collision on the WAIT->RESP edge: old word returned.
    push(32'hA000_0001, 1'b0);
    bus.instr_mem_en      = 1'b1;
    bus.instr_mem_address = 32'h44;
    step();
    bus.instr_mem_en = 1'b0;
    bus.load_we      = 1'b1;
    bus.load_addr    = IDX_W'(1);
    bus.load_data    = 32'h1234_5678;
    step();
    bus.load_we = 1'b0;
    @(negedge clk);
    check("coll_ready", 32'(bus.instr_ready), 32'd1);
    step();
    fetch(32'h44, 32'h1234_5678, 1'b0, "coll_new");

    // Reset in WAIT: reset values next cycle, no response, memory retained.
    bus.instr_mem_en      = 1'b1;
    bus.instr_mem_address = 32'h10;
    step();
    bus.instr_mem_en = 1'b0;
    rst              = 1'b1;
    @(negedge clk);
    check("rstw_busy_before", 32'(bus.busy), 32'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstw_read", bus.instr_mem_read, NOP);
    check("rstw_ready", 32'(bus.instr_ready), 32'd0);
    check("rstw_busy", 32'(bus.busy), 32'd0);
    check("rstw_misalign", 32'(bus.misalign), 32'd0);
    quiet(6, "rstw_no_resp");
    fetch(32'h10, 32'hDEAD_BEEF, 1'b0, "after_rst");

    repeat (4) step();
    check("queue_empty", 32'(sb_q.size()), 32'd0);
    check("pulse_count", 32'(pulses), 32'(pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Testbench-side responder for the core's instruction-fetch port. It holds a word-addressed instruction memory that the bench preloads through a backdoor write port. It answers each fetch request (`instr_mem_en`, `instr_mem_address`) after a programmable latency with `instr_mem_read` and a one-cycle `instr_ready` pulse, and it honours `instr_mem_flush`. It sits between the sequence/driver layer and the DUT fetch unit.

## Interface
- `DEPTH`, 4096: memory size in 32-bit words; power of two; `IDX_W = $clog2(DEPTH)`.
- `LATENCY`, 2: cycles from request acceptance to the `instr_ready` pulse; legal values 1..15.
- `NOP_INSTR`, 32'h0000_0013: value driven on `instr_mem_read` after reset or flush.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_mem_en`  in  1  fetch request, sampled only when the block can accept one.
- `instr_mem_address`  in  32  fetch byte address.
- `instr_mem_flush`  in  1  cancels any in-flight fetch.
- `instr_mem_read`  out  32  fetched instruction word.
- `instr_ready`  out  1  one-cycle pulse: `instr_mem_read` is valid.
- `busy`  out  1  a fetch is in flight (WAIT state).
- `misalign`  out  1  one-cycle error pulse with `instr_ready` (see Configuration).
- `load_we`  in  1  backdoor word write.
- `load_addr`  in  IDX_W  backdoor word index.
- `load_data`  in  32  backdoor write data.

## Operation
- The state machine has three states: IDLE, WAIT, RESP.
- **IDLE**
  - If `instr_mem_en` is high and `instr_mem_flush` is low: capture `idx = instr_mem_address[IDX_W+1:2]`.
  - Address bits above `IDX_W+1` are ignored, so addresses wrap modulo DEPTH.
  - Load the counter with `LATENCY-1`.
  - Go to WAIT, or go directly to RESP when `LATENCY == 1`.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 0, register `mem[idx]` into `instr_mem_read` and go to RESP.
- **RESP**
  - `instr_ready` = 1 for exactly this cycle.
  - A new request with `instr_mem_en` high in RESP is accepted immediately, with the same capture rules as IDLE.
  - Without a new request, return to IDLE.
- `instr_mem_read` holds its last value until the next response or flush.
- **Flush**
  - In any state, `instr_mem_flush` high forces IDLE on the next edge.
  - `instr_mem_read` becomes `NOP_INSTR` on that edge.
  - If the flush arrives in the RESP cycle, that cycle's `instr_ready` still shows 1.
  - A request presented with flush is not accepted.
- **Backdoor write**
  - When `load_we` is high, `mem[load_addr] <= load_data` at the edge.
  - Writes are allowed in any state.
  - If a write hits the same word as a same-cycle read (the WAIT→RESP edge), the read returns the old data (read-before-write).
- **Reset**
  - Reset forces IDLE, clears the counter, drives `instr_mem_read = NOP_INSTR`, and drives `instr_ready`, `busy` and `misalign` to 0.
  - Memory contents are not cleared.

## Timing
- A request accepted at edge N produces `instr_ready` high in cycle N+LATENCY.
- Back-to-back requests give one response every `LATENCY` cycles; there is no bubble when the next request is presented in RESP.
- `busy` is high exactly in WAIT.
- A reset or flush asserted mid-fetch takes effect at the next edge; no later `instr_ready` pulse is issued for the cancelled fetch.
- All outputs are registered or derived from state only, with no combinational path from the inputs.

## Configuration
- Macro: `INSTR_MEM_MISALIGN_CHECK_EN`.
- **Defined:**
  - A request with `instr_mem_address[1:0] != 0` is accepted normally.
  - Its RESP cycle asserts `misalign` = 1 and returns `NOP_INSTR` instead of the memory word.
- **Undefined:**
  - `instr_mem_address[1:0]` is ignored.
  - `misalign` is tied to 0.

## Structure
- Package `instr_mem_pkg`:
  - state enum `instr_mem_state_e` {IDLE, WAIT, RESP};
  - `NOP_INSTR_DEFAULT` constant;
  - counter width constant `LAT_CNT_W = 4`.
- Sub-module `instr_mem_array`: DEPTH×32 storage, one synchronous write port, one synchronous read port with read-before-write semantics.
- The top level contains the FSM, counter, address capture, flush logic and misalign logic.

## Test plan
- **Basic read:** preload `mem[4]` = 32'hDEAD_BEEF with LATENCY=2; request address 32'h10 at cycle 0 → `instr_ready` high at cycle 2 only, `instr_mem_read` = 32'hDEAD_BEEF, `busy` high at cycle 1.
- **Back-to-back:** hold `instr_mem_en` with addresses 0x0, 0x4, 0x8 presented in each acceptance cycle → three `instr_ready` pulses at cycles 2, 4, 6 with the matching preloaded words.
- **Flush mid-fetch:** request at cycle 0, flush at cycle 1 → no `instr_ready`, `instr_mem_read` = 32'h0000_0013 from cycle 2, state is IDLE.
- **Wrap and collision:** DEPTH=16; request address 32'h0000_0044 → returns `mem[1]`. A backdoor write of 32'h1234_5678 to `mem[1]` on the WAIT→RESP edge → response carries the old word; a second fetch returns 32'h1234_5678.
- **Reset mid-fetch:** assert `rst` in WAIT → next cycle all outputs are at reset values, and no response follows.
- **Misalign (macro defined):** request address 32'h0000_0012 → `misalign` = 1 with `instr_ready`, and `instr_mem_read` = 32'h0000_0013.
